reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- 32-entry x 32-bit register file for the Lab5 datapath: one synchronous write port and two combinational read ports.
- Read ports feed the ALU operand buses; register 0 is hardwired to zero.
- Adds a debug dump sequencer that streams all 32 entries out, one per cycle, on request.
- Storage is the reader/writer counterpart to the single 32-bit register: reg_32bit holds a value; this block addresses, writes and reads many.

Parameters:
- WIDTH, 32, data width of each entry.
- DEPTH, 32, number of entries; must be a power of two.
- ADDR_W, 5, address width; must equal log2(DEPTH).
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; entries and dump FSM clear when 0.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- raddr_a  input  ADDR_W  read port A address.
- rdata_a  output  WIDTH  read port A data, combinational.
- raddr_b  input  ADDR_W  read port B address.
- rdata_b  output  WIDTH  read port B data, combinational.
- dump_start  input  1  one-cycle pulse that requests a full dump.
- dump_busy  output  1  high while a dump is in progress.
- dump_valid  output  1  dump_data and dump_idx are valid this cycle.
- dump_idx  output  ADDR_W  index of the entry being dumped.
- dump_data  output  WIDTH  contents of entry dump_idx.

Behaviour:
- Reset: when reset=0, all entries become 0 immediately (asynchronously). The FSM goes to IDLE; dump_busy=0, dump_valid=0, dump_idx=0, dump_data=0. Reset asserted mid-dump aborts the dump with no further dump_valid.
- Write: if we=1 and waddr!=0, entry[waddr] <= wdata at the rising edge. Writes to address 0 are silently dropped.
- Read: rdata_x = 0 if raddr_x==0, otherwise entry[raddr_x]. Zero latency.
- Bypass (BYPASS=1): if we=1, waddr==raddr_x and waddr!=0, then rdata_x=wdata in the same cycle. With BYPASS=0, a read returns the old value until the edge.
- Both read ports may address the same entry; each returns an identical value.
- Dump FSM, two states:
  - IDLE: on dump_start=1 -> DUMP with counter cnt=0.
  - DUMP: each cycle drives registered dump_valid=1, dump_idx=cnt, dump_data=entry[cnt] as sampled at the previous edge. Entry 0 always reads 0. cnt increments by 1; after cnt=DEPTH-1 is emitted -> IDLE.
- Dump timing:
  - First dump_valid appears 1 cycle after dump_start is sampled.
  - Exactly DEPTH valid beats are produced, back to back.
  - dump_busy=1 from the cycle after dump_start through the last valid beat.
- dump_start while busy is ignored; there is no restart and no queuing.
- Writes during a dump are allowed:
  - An entry written before its index is dumped shows the new value.
  - An entry written in the same cycle its index is sampled shows the old value (no bypass on the dump path).
- cnt is ADDR_W wide and is not allowed to wrap past DEPTH-1; the FSM exits instead.

Decomposition:
- Shared package rf_pkg holds REG_W=32, RF_DEPTH=32, RF_ADDR_W=5, the ZERO_REG=0 constant, and the dump state enum (IDLE, DUMP).
- One natural sub-module, reg_32bit_we_ar: a 32-bit register with write enable and asynchronous active-low clear. It is instantiated DEPTH-1 times via generate; entry 0 is constant zero with no flops.
- Read muxes, bypass compare and the dump FSM live in the top module.

Test Plan:
- Reset: hold reset=0 with we=1, waddr=3, wdata=0xDEADBEEF. Release reset, then read addr 3 -> rdata=0. Assert reset low mid-cycle -> all reads return 0 without waiting for a clock edge.
- Write/read: write 0x12345678 to addr 7. Next cycle read A=7, B=7 -> both 0x12345678. Write 0xFFFFFFFF to addr 0 -> reading addr 0 returns 0.
- Bypass: addr 9 holds 0x1. In one cycle drive we=1, waddr=9, wdata=0xA5A5A5A5, raddr_a=9 -> rdata_a=0xA5A5A5A5 in that cycle, with BYPASS=1 (0x1 with BYPASS=0).
- Full dump: preload entry i = i*0x01010101. Pulse dump_start -> 32 consecutive beats with dump_idx=0..31 and dump_data=i*0x01010101 (idx 0 -> 0). dump_busy is high for exactly 32 cycles.
- Dump collisions:
  - dump_start re-pulsed at beat 10 -> ignored; still exactly 32 beats.
  - Write 0xCAFEF00D to addr 20 at beat 5 -> beat 20 shows 0xCAFEF00D.
  - Write addr 12 in the cycle it is sampled -> beat shows the old value.
- Reset mid-dump: assert reset=0 at beat 15 -> dump_valid and dump_busy drop immediately. After release, a new dump_start yields 32 beats of 0.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared sizes, zero-register constant and dump FSM states for the register file
package rf_pkg;
  localparam int REG_W     = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = 5;
  localparam int ZERO_REG  = 0;
  typedef enum logic {IDLE, DUMP} dump_state_t;
endpackage

// File: rtl/reg_32bit_we_ar.sv
// reg_32bit_we_ar: register with write enable and asynchronous active-low clear
module reg_32bit_we_ar
  import rf_pkg::*;
#(
  parameter int WIDTH = REG_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_q <= '0;
    else if (i_we) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write register file with hardwired-zero entry 0 and a debug dump sequencer
module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter int WIDTH  = REG_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [WIDTH-1:0]  dump_data
);
  logic [WIDTH-1:0]  w_ent [DEPTH];
  logic              w_wr_ok, w_hit_a, w_hit_b, w_emit, w_last;
  logic [ADDR_W-1:0] w_idx;
  dump_state_t       r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, r_dump_idx;
  logic              r_dump_valid;
  logic [WIDTH-1:0]  r_dump_data;

  assign w_ent[0] = '0;
  assign w_wr_ok  = we && (waddr != ADDR_W'(ZERO_REG));

  genvar g;
  for (g = 1; g < DEPTH; g++) begin : g_ent
    reg_32bit_we_ar #(.WIDTH(WIDTH)) u_reg (
      .i_clk  (clk),
      .i_rst_n(reset),
      .i_we   (w_wr_ok && (waddr == ADDR_W'(g))),
      .i_d    (wdata),
      .o_q    (w_ent[g])
    );
  end

  always_comb begin
    w_hit_a = BYPASS && w_wr_ok && (waddr == raddr_a);
    w_hit_b = BYPASS && w_wr_ok && (waddr == raddr_b);
    rdata_a = w_hit_a ? wdata : w_ent[raddr_a];
    rdata_b = w_hit_b ? wdata : w_ent[raddr_b];
  end

  // a start is only accepted once the previous dump's last beat has left the output
  always_comb begin
    w_emit = (r_state == DUMP) || (dump_start && !r_dump_valid);
    w_idx  = (r_state == DUMP) ? r_cnt : '0;
    w_last = w_idx == ADDR_W'(DEPTH - 1);
    w_next = (w_emit && !w_last) ? DUMP : IDLE;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_emit && !w_last) ? w_idx + 1'b1 : '0;
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_dump_valid <= 1'b0;
      r_dump_idx   <= '0;
      r_dump_data  <= '0;
    end else begin
      r_dump_valid <= w_emit;
      r_dump_idx   <= w_emit ? w_idx : '0;
      r_dump_data  <= w_emit ? w_ent[w_idx] : '0;
    end

  assign dump_busy  = r_dump_valid;
  assign dump_valid = r_dump_valid;
  assign dump_idx   = r_dump_idx;
  assign dump_data  = r_dump_data;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: scoreboard bench for reads, writes, bypass and the dump sequencer
module tb_reg_file_2r1w;
  logic        clk = 1'b0, reset = 1'b0, we = 1'b0, dump_start = 1'b0;
  logic [4:0]  waddr = '0, raddr_a = '0, raddr_b = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_a, rdata_b, dump_data;
  logic [4:0]  dump_idx;
  logic        dump_busy, dump_valid;

  typedef struct {logic [4:0] idx; logic [31:0] data;} beat_t;
  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [31:0] mem [32];
  int          checks = 0, failures = 0, beats = 0;

  reg_file_2r1w dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (dump_valid === 1'b1) begin
      beats++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL dump_extra got idx=%0d data=%h exp=no beat", dump_idx, dump_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (dump_idx !== mon_e.idx || dump_data !== mon_e.data) begin
          failures++;
          $display("FAIL dump_beat got idx=%0d data=%h exp idx=%0d data=%h",
                   dump_idx, dump_data, mon_e.idx, mon_e.data);
        end
      end
    end

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
    if (a != 5'd0) mem[a] = d;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF; raddr_a = 5'd3;
    repeat (3) @(negedge clk);
    checks++;
    if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_dump_outs got busy=%b valid=%b idx=%0d data=%h exp all 0",
               dump_busy, dump_valid, dump_idx, dump_data);
    end
    reset = 1'b1; we = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata_a !== 32'd0) begin
      failures++; $display("FAIL reset_write_blocked got=%h exp=%h", rdata_a, 32'd0);
    end
    do_write(5'd3, 32'h55AA55AA);
    raddr_a = 5'd3; raddr_b = 5'd3;
    #1 checks++;
    if (rdata_a !== 32'h55AA55AA) begin
      failures++; $display("FAIL pre_async_reset got=%h exp=%h", rdata_a, 32'h55AA55AA);
    end
    #1 reset = 1'b0;
    #1 checks++;
    if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin
      failures++; $display("FAIL async_reset_clear got a=%h b=%h exp=0", rdata_a, rdata_b);
    end
    @(negedge clk);
    reset = 1'b1;
    mem[3] = '0;
  endtask

  task automatic test_write_read();
    logic [4:0]  a;
    logic [31:0] d;
    do_write(5'd7, 32'h12345678);
    raddr_a = 5'd7; raddr_b = 5'd7;
    #1 checks++;
    if (rdata_a !== 32'h12345678 || rdata_b !== 32'h12345678) begin
      failures++; $display("FAIL read_same_addr got a=%h b=%h exp=%h", rdata_a, rdata_b, 32'h12345678);
    end
    do_write(5'd0, 32'hFFFFFFFF);
    raddr_a = 5'd0; raddr_b = 5'd0;
    #1 checks++;
    if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin
      failures++; $display("FAIL write_addr0_dropped got a=%h b=%h exp=0", rdata_a, rdata_b);
    end
    for (int k = 0; k < 8; k++) begin
      a = 5'($urandom_range(1, 31));
      d = $urandom;
      do_write(a, d);
    end
    for (int k = 0; k < 8; k++) begin
      raddr_a = 5'($urandom_range(0, 31));
      raddr_b = 5'($urandom_range(0, 31));
      #1 checks++;
      if (rdata_a !== mem[raddr_a] || rdata_b !== mem[raddr_b]) begin
        failures++;
        $display("FAIL random_read got a[%0d]=%h b[%0d]=%h exp a=%h b=%h",
                 raddr_a, rdata_a, raddr_b, rdata_b, mem[raddr_a], mem[raddr_b]);
      end
    end
  endtask

  task automatic test_bypass();
    do_write(5'd9, 32'h1);
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; raddr_a = 5'd9; raddr_b = 5'd7;
    #1 checks++;
    if (rdata_a !== 32'hA5A5A5A5 || rdata_b !== mem[7]) begin
      failures++; $display("FAIL bypass_hit got a=%h b=%h exp a=%h b=%h", rdata_a, rdata_b, 32'hA5A5A5A5, mem[7]);
    end
    @(negedge clk);
    waddr = 5'd0; wdata = 32'h77777777; raddr_a = 5'd0;
    #1 checks++;
    if (rdata_a !== 32'd0) begin
      failures++; $display("FAIL bypass_addr0 got=%h exp=%h", rdata_a, 32'd0);
    end
    @(negedge clk);
    we = 1'b0; mem[9] = 32'hA5A5A5A5; raddr_a = 5'd9;
    #1 checks++;
    if (rdata_a !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL bypass_committed got=%h exp=%h", rdata_a, 32'hA5A5A5A5);
    end
  endtask

  // Stimulus index n is driven at the n-th falling edge after the start pulse and commits at the
  // following rising edge; beat k samples storage at that same rising edge k, so only writes with n<k show.
  task automatic run_dump(input int re_at, input int w1_at, input logic [4:0] w1_a, input logic [31:0] w1_d,
                          input int w2_at, input logic [4:0] w2_a, input logic [31:0] w2_d);
    beat_t e;
    int    busy_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      e.idx  = 5'(i);
      e.data = mem[i];
      if (w1_at >= 0 && w1_at < i && int'(w1_a) == i) e.data = w1_d;
      if (w2_at >= 0 && w2_at < i && int'(w2_a) == i) e.data = w2_d;
      exp_q.push_back(e);
    end
    beats = 0;
    @(negedge clk);
    dump_start = 1'b1; we = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (dump_busy === 1'b1) busy_cnt++;
      dump_start = (n == re_at);
      we = 1'b0;
      if (n == w1_at) begin we = 1'b1; waddr = w1_a; wdata = w1_d; end
      if (n == w2_at) begin we = 1'b1; waddr = w2_a; wdata = w2_d; end
    end
    if (w1_at >= 0) mem[w1_a] = w1_d;
    if (w2_at >= 0) mem[w2_a] = w2_d;
    checks++;
    if (beats != 32 || busy_cnt != 32 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL dump_count got beats=%0d busy=%0d left=%0d exp 32/32/0", beats, busy_cnt, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_full_dump();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101);
    run_dump(-1, -1, 5'd0, 32'd0, -1, 5'd0, 32'd0);
  endtask

  task automatic test_dump_collisions();
    run_dump(10, 5, 5'd20, 32'hCAFEF00D, 12, 5'd12, 32'hBEEF0012);
    raddr_a = 5'd12; raddr_b = 5'd20;
    #1 checks++;
    if (rdata_a !== 32'hBEEF0012 || rdata_b !== 32'hCAFEF00D) begin
      failures++; $display("FAIL dump_writes_landed got a=%h b=%h exp a=%h b=%h",
                           rdata_a, rdata_b, 32'hBEEF0012, 32'hCAFEF00D);
    end
  endtask

  task automatic test_reset_mid_dump();
    beat_t e;
    for (int i = 0; i < 16; i++) begin
      e.idx = 5'(i); e.data = mem[i]; exp_q.push_back(e);
    end
    beats = 0;
    @(negedge clk);
    dump_start = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      dump_start = 1'b0;
    end
    raddr_a = 5'd31;
    #2 reset = 1'b0;
    #1 checks++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || rdata_a !== 32'd0) begin
      failures++; $display("FAIL reset_mid_dump got valid=%b busy=%b rd=%h exp 0/0/0", dump_valid, dump_busy, rdata_a);
    end
    checks++;
    if (beats != 16 || exp_q.size() != 0) begin
      failures++; $display("FAIL beats_before_reset got=%0d exp=16", beats);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (dump_valid !== 1'b0) begin
      failures++; $display("FAIL no_beats_after_abort got valid=%b exp=0", dump_valid);
    end
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    run_dump(-1, -1, 5'd0, 32'd0, -1, 5'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_full_dump();
    test_dump_collisions();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
